// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the Data_Mem initiator pipeline: op classes,
// datapath widths and the load-use stall FSM encoding.
package mem_access_ctrl_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 2;   // holds LOAD_STALL-1 for LOAD_STALL in 1..3

    localparam logic [OP_W-1:0] OP_NOP   = 2'b00;
    localparam logic [OP_W-1:0] OP_ALU   = 2'b01;
    localparam logic [OP_W-1:0] OP_LOAD  = 2'b10;
    localparam logic [OP_W-1:0] OP_STORE = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_hazard_unit.sv
// Load-use hazard compare between the ID-stage operands and a LOAD in EX.
// Ports:
//   valid_id, src1_id, src2_id, src2_used_id : ID-stage operand info
//   op_ex, dst_ex                            : instruction currently in EX
//   hazard_c                                 : combinational hazard flag
module hazard_unit
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 3
) (
    input  logic              valid_id,
    input  logic [OP_W-1:0]   op_ex,
    input  logic [REG_AW-1:0] dst_ex,
    input  logic [REG_AW-1:0] src1_id,
    input  logic [REG_AW-1:0] src2_id,
    input  logic              src2_used_id,
    output logic              hazard_c
);

    logic src1_hit;
    logic src2_hit;

    assign src1_hit = (src1_id == dst_ex);
    assign src2_hit = src2_used_id && (src2_id == dst_ex);
    assign hazard_c = valid_id && (op_ex == OP_LOAD) && (src1_hit || src2_hit);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the Data_Mem interface. Carries ID-stage memory decode
// through EX and DM pipeline registers, drives the Data_Mem request pins,
// stalls ID on load-use hazards and supplies write-back control.
// Ports:
//   clk, reset (async, active-low)
//   ID in : valid_id, op_id, dst_id, src1_id, src2_id, src2_used_id
//   EX in : flush, alu_res, st_data
//   Data_Mem out : ans_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm
//   WB out : wb_en_dm, wb_dst_dm
//   stall_id : hold PC and IF/ID this cycle
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 3,
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_id,
    input  logic [OP_W-1:0]   op_id,
    input  logic [REG_AW-1:0] dst_id,
    input  logic [REG_AW-1:0] src1_id,
    input  logic [REG_AW-1:0] src2_id,
    input  logic              src2_used_id,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] ans_ex,
    output logic [DATA_W-1:0] DM_data,
    output logic              mem_en_ex,
    output logic              mem_rw_ex,
    output logic              mem_mux_sel_dm,
    output logic              wb_en_dm,
    output logic [REG_AW-1:0] wb_dst_dm,
    output logic              stall_id
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_ex_q, op_ex_d;
    logic [REG_AW-1:0] dst_ex_q, dst_ex_d;
    logic              mem_mux_sel_dm_q, mem_mux_sel_dm_d;
    logic              wb_en_dm_q, wb_en_dm_d;
    logic [REG_AW-1:0] wb_dst_dm_q, wb_dst_dm_d;
    logic              hazard_c;
    logic              stall_c;

    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard_unit (
        .valid_id     (valid_id),
        .op_ex        (op_ex_q),
        .dst_ex       (dst_ex_q),
        .src1_id      (src1_id),
        .src2_id      (src2_id),
        .src2_used_id (src2_used_id),
        .hazard_c     (hazard_c)
    );

    // Stall FSM, EX capture and DM advance.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        stall_c          = 1'b0;
        op_ex_d          = OP_NOP;
        dst_ex_d         = '0;
        mem_mux_sel_dm_d = (op_ex_q == OP_LOAD);
        wb_en_dm_d       = (op_ex_q == OP_ALU) || (op_ex_q == OP_LOAD);
        wb_dst_dm_d      = dst_ex_q;

        case (state_q)
            ST_RUN: begin
                stall_c = hazard_c;
                // First bubble is this cycle; extra bubbles come from STALL.
                if (hazard_c && (LOAD_STALL > 1)) begin
                    state_d = ST_STALL;
                    cnt_d   = CNT_W'(LOAD_STALL - 1);
                end
            end
            ST_STALL: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // A taken branch kills EX and abandons any pending stall.
        if (flush) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end

        if (valid_id && !stall_c && !flush) begin
            op_ex_d  = op_id;
            dst_ex_d = dst_id;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_RUN;
            cnt_q            <= '0;
            op_ex_q          <= OP_NOP;
            dst_ex_q         <= '0;
            mem_mux_sel_dm_q <= 1'b0;
            wb_en_dm_q       <= 1'b0;
            wb_dst_dm_q      <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            op_ex_q          <= op_ex_d;
            dst_ex_q         <= dst_ex_d;
            mem_mux_sel_dm_q <= mem_mux_sel_dm_d;
            wb_en_dm_q       <= wb_en_dm_d;
            wb_dst_dm_q      <= wb_dst_dm_d;
        end
    end

    // EX data passes straight through so it lines up with the registered EX controls.
    assign ans_ex         = alu_res;
    assign DM_data        = st_data;
    assign mem_en_ex      = op_ex_q[1];
    assign mem_rw_ex      = (op_ex_q == OP_STORE);
    assign mem_mux_sel_dm = mem_mux_sel_dm_q;
    assign wb_en_dm       = wb_en_dm_q;
    assign wb_dst_dm      = wb_dst_dm_q;
    assign stall_id       = stall_c;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: two instances share the ID/EX inputs,
// one with a single load-use bubble, one with three.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_id;
    logic [1:0] op_id;
    logic [2:0] dst_id, src1_id, src2_id;
    logic       src2_used_id;
    logic       flush;
    logic [7:0] alu_res, st_data;

    logic [7:0] ans_a, dmd_a, ans_b, dmd_b;
    logic       en_a, rw_a, mux_a, wb_en_a, stall_a;
    logic       en_b, rw_b, mux_b, wb_en_b, stall_b;
    logic [2:0] wb_dst_a, wb_dst_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.REG_AW(3), .LOAD_STALL(1)) u_dut_a (
        .clk(clk), .reset(reset), .valid_id(valid_id), .op_id(op_id), .dst_id(dst_id),
        .src1_id(src1_id), .src2_id(src2_id), .src2_used_id(src2_used_id), .flush(flush),
        .alu_res(alu_res), .st_data(st_data), .ans_ex(ans_a), .DM_data(dmd_a),
        .mem_en_ex(en_a), .mem_rw_ex(rw_a), .mem_mux_sel_dm(mux_a), .wb_en_dm(wb_en_a),
        .wb_dst_dm(wb_dst_a), .stall_id(stall_a)
    );

    mem_access_ctrl #(.REG_AW(3), .LOAD_STALL(3)) u_dut_b (
        .clk(clk), .reset(reset), .valid_id(valid_id), .op_id(op_id), .dst_id(dst_id),
        .src1_id(src1_id), .src2_id(src2_id), .src2_used_id(src2_used_id), .flush(flush),
        .alu_res(alu_res), .st_data(st_data), .ans_ex(ans_b), .DM_data(dmd_b),
        .mem_en_ex(en_b), .mem_rw_ex(rw_b), .mem_mux_sel_dm(mux_b), .wb_en_dm(wb_en_b),
        .wb_dst_dm(wb_dst_b), .stall_id(stall_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic [2:0] dst,
                          input logic [2:0] s1, input logic [2:0] s2, input logic s2u);
        valid_id = v; op_id = op; dst_id = dst; src1_id = s1; src2_id = s2; src2_used_id = s2u;
    endtask

    task automatic drain();
        set_id(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        flush = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; alu_res = 8'h00; st_data = 8'h00;
        set_id(1'b1, 2'b10, 3'd2, 3'd1, 3'd0, 1'b0);
        tick(); tick(); #1;
        n_tests++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall_a); end
        n_tests++; if (en_a !== 1'b0 || rw_a !== 1'b0) begin n_fail++; $display("FAIL rst_en_rw: got %0b%0b want 00", en_a, rw_a); end
        n_tests++; if (mux_a !== 1'b0 || wb_en_a !== 1'b0 || wb_dst_a !== 3'd0) begin n_fail++; $display("FAIL rst_dm: got mux=%0b wb=%0b dst=%0d want 0 0 0", mux_a, wb_en_a, wb_dst_a); end
        n_tests++; if (en_b !== 1'b0 || stall_b !== 1'b0) begin n_fail++; $display("FAIL rst_b: got en=%0b stall=%0b want 0 0", en_b, stall_b); end
        reset = 1'b1;
        tick(); #1;
        n_tests++; if (en_a !== 1'b1 || rw_a !== 1'b0) begin n_fail++; $display("FAIL rel_load_ex: got en=%0b rw=%0b want 1 0", en_a, rw_a); end
        set_id(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        tick(); #1;
        n_tests++; if (mux_a !== 1'b1 || wb_en_a !== 1'b1 || wb_dst_a !== 3'd2 || en_a !== 1'b0) begin n_fail++; $display("FAIL rel_load_dm: got mux=%0b wb=%0b dst=%0d en=%0b want 1 1 2 0", mux_a, wb_en_a, wb_dst_a, en_a); end
    endtask

    task automatic test_store_alu();
        drain();
        set_id(1'b1, 2'b11, 3'd5, 3'd1, 3'd3, 1'b1);
        tick();
        set_id(1'b1, 2'b01, 3'd4, 3'd6, 3'd7, 1'b1);
        alu_res = 8'h03; st_data = 8'hFF; #1;
        n_tests++; if (ans_a !== 8'h03 || dmd_a !== 8'hFF) begin n_fail++; $display("FAIL store_data: got ans=%0h dm=%0h want 03 ff", ans_a, dmd_a); end
        n_tests++; if (en_a !== 1'b1 || rw_a !== 1'b1) begin n_fail++; $display("FAIL store_ex: got en=%0b rw=%0b want 1 1", en_a, rw_a); end
        tick();
        set_id(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        alu_res = 8'h5A; #1;
        n_tests++; if (wb_en_a !== 1'b0 || mux_a !== 1'b0) begin n_fail++; $display("FAIL store_dm: got wb=%0b mux=%0b want 0 0", wb_en_a, mux_a); end
        n_tests++; if (en_a !== 1'b0 || rw_a !== 1'b0 || ans_a !== 8'h5A) begin n_fail++; $display("FAIL alu_ex: got en=%0b rw=%0b ans=%0h want 0 0 5a", en_a, rw_a, ans_a); end
        tick(); #1;
        n_tests++; if (wb_en_a !== 1'b1 || wb_dst_a !== 3'd4 || mux_a !== 1'b0) begin n_fail++; $display("FAIL alu_dm: got wb=%0b dst=%0d mux=%0b want 1 4 0", wb_en_a, wb_dst_a, mux_a); end
    endtask

    task automatic test_load_use();
        int cnt_a;
        int cnt_b;
        logic exp_sa [6];
        logic exp_sb [6];
        exp_sa = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_sb = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        cnt_a = 0; cnt_b = 0;
        drain();
        set_id(1'b1, 2'b10, 3'd2, 3'd1, 3'd0, 1'b0);
        tick();
        set_id(1'b1, 2'b01, 3'd3, 3'd2, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (stall_a === 1'b1) cnt_a++;
            if (stall_b === 1'b1) cnt_b++;
            n_tests++; if (stall_a !== exp_sa[i] || stall_b !== exp_sb[i]) begin n_fail++; $display("FAIL lu_stall_c%0d: got a=%0b b=%0b want %0b %0b", i, stall_a, stall_b, exp_sa[i], exp_sb[i]); end
            if (i == 1) begin
                n_tests++; if (mux_a !== 1'b1 || wb_dst_a !== 3'd2 || wb_en_a !== 1'b1 || en_a !== 1'b0) begin n_fail++; $display("FAIL lu_a_dm_load: got mux=%0b dst=%0d wb=%0b en=%0b want 1 2 1 0", mux_a, wb_dst_a, wb_en_a, en_a); end
                n_tests++; if (mux_b !== 1'b1 || wb_dst_b !== 3'd2 || en_b !== 1'b0) begin n_fail++; $display("FAIL lu_b_dm_load: got mux=%0b dst=%0d en=%0b want 1 2 0", mux_b, wb_dst_b, en_b); end
            end
            if (i == 2) begin
                n_tests++; if (wb_en_a !== 1'b0) begin n_fail++; $display("FAIL lu_a_bubble: got wb=%0b want 0", wb_en_a); end
            end
            if (i == 3) begin
                n_tests++; if (wb_en_a !== 1'b1 || wb_dst_a !== 3'd3) begin n_fail++; $display("FAIL lu_a_alu_dm: got wb=%0b dst=%0d want 1 3", wb_en_a, wb_dst_a); end
            end
            if (i == 4) begin
                n_tests++; if (wb_en_b !== 1'b0) begin n_fail++; $display("FAIL lu_b_bubble: got wb=%0b want 0", wb_en_b); end
            end
            if (i == 5) begin
                n_tests++; if (wb_en_b !== 1'b1 || wb_dst_b !== 3'd3) begin n_fail++; $display("FAIL lu_b_alu_dm: got wb=%0b dst=%0d want 1 3", wb_en_b, wb_dst_b); end
            end
            tick();
        end
        n_tests++; if (cnt_a != 1 || cnt_b != 3) begin n_fail++; $display("FAIL lu_stall_count: got a=%0d b=%0d want 1 3", cnt_a, cnt_b); end
    endtask

    task automatic test_no_hazard();
        drain();
        set_id(1'b1, 2'b10, 3'd2, 3'd1, 3'd0, 1'b0);
        tick();
        set_id(1'b1, 2'b11, 3'd0, 3'd1, 3'd2, 1'b0);
        #1;
        n_tests++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin n_fail++; $display("FAIL nh_stall: got a=%0b b=%0b want 0 0", stall_a, stall_b); end
        tick();
        set_id(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        #1;
        n_tests++; if (en_a !== 1'b1 || rw_a !== 1'b1 || mux_a !== 1'b1) begin n_fail++; $display("FAIL nh_b2b: got en=%0b rw=%0b mux=%0b want 1 1 1", en_a, rw_a, mux_a); end
        n_tests++; if (en_b !== 1'b1 || rw_b !== 1'b1) begin n_fail++; $display("FAIL nh_b2b_b: got en=%0b rw=%0b want 1 1", en_b, rw_b); end
        drain();
        set_id(1'b1, 2'b10, 3'd2, 3'd1, 3'd0, 1'b0);
        tick();
        set_id(1'b1, 2'b11, 3'd0, 3'd1, 3'd2, 1'b1);
        #1;
        n_tests++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL src2_hazard: got %0b want 1", stall_a); end
        tick();
        set_id(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        #1;
        n_tests++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL src2_bubble: got en=%0b want 0", en_a); end
    endtask

    task automatic test_flush();
        drain();
        set_id(1'b1, 2'b10, 3'd2, 3'd1, 3'd0, 1'b0);
        tick();
        set_id(1'b1, 2'b01, 3'd3, 3'd2, 3'd0, 1'b0);
        #1;
        n_tests++; if (stall_b !== 1'b1) begin n_fail++; $display("FAIL fl_stall_c0: got %0b want 1", stall_b); end
        tick();
        flush = 1'b1; #1;
        n_tests++; if (stall_b !== 1'b1) begin n_fail++; $display("FAIL fl_stall_c1: got %0b want 1", stall_b); end
        tick();
        flush = 1'b0; #1;
        n_tests++; if (stall_b !== 1'b0 || en_b !== 1'b0) begin n_fail++; $display("FAIL fl_after: got stall=%0b en=%0b want 0 0", stall_b, en_b); end
        tick(); tick(); #1;
        n_tests++; if (wb_en_b !== 1'b1 || wb_dst_b !== 3'd3) begin n_fail++; $display("FAIL fl_alu_dm: got wb=%0b dst=%0d want 1 3", wb_en_b, wb_dst_b); end
    endtask

    task automatic test_async_reset();
        drain();
        set_id(1'b1, 2'b10, 3'd2, 3'd1, 3'd0, 1'b0);
        tick();
        set_id(1'b1, 2'b01, 3'd3, 3'd2, 3'd0, 1'b0);
        tick(); #1;
        n_tests++; if (stall_b !== 1'b1 || mux_b !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got stall=%0b mux=%0b want 1 1", stall_b, mux_b); end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (stall_b !== 1'b0 || mux_b !== 1'b0 || wb_en_b !== 1'b0 || wb_dst_b !== 3'd0 || en_b !== 1'b0) begin n_fail++; $display("FAIL ar_clear: got stall=%0b mux=%0b wb=%0b dst=%0d en=%0b want 0 0 0 0 0", stall_b, mux_b, wb_en_b, wb_dst_b, en_b); end
        #2 reset = 1'b1;
        #1;
        n_tests++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL ar_release: got %0b want 0", stall_b); end
        tick(); #1;
        n_tests++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL ar_no_leftover: got %0b want 0", stall_b); end
    endtask

    initial begin
        test_reset();
        test_store_alu();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
